// File: rtl/iter_mac.sv
// rtl/iter_mac.sv - iterative shift-add multiply / multiply-accumulate unit (optional ITER_MAC_SAT_EN: saturating MAC accumulator)
module iter_mac #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   result
);

    localparam int CW = $clog2(W);

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_MUL = 2'b01;
    localparam logic [1:0] MODE_MAC = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          state;
    state_t          state_nx;

    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  mcand;
    logic [W-1:0]    mplier;
    logic [2*W-1:0]  prod;
    logic [2*W-1:0]  prod_nx;
    logic [2*W-1:0]  acc;
    logic [2*W-1:0]  mac_val;
    logic            is_mac;
    logic            last_step;
    logic [W:0]      add_sum;
    logic [2*W-1:0]  add_ext;

    assign last_step = (cnt == CW'(W - 1));

    // ADD keeps the carry out of the W-bit sum, then zero-extends to the result width
    assign add_sum = {1'b0, a} + {1'b0, b};
    assign add_ext = {{(W-1){1'b0}}, add_sum};

    // one LSB-first shift-add step: add the shifted multiplicand when the current multiplier bit is set
    assign prod_nx = mplier[0] ? (prod + mcand) : prod;

`ifdef ITER_MAC_SAT_EN
    logic [2*W:0] mac_sum;
    // extra carry bit detects accumulator overflow so it can clamp to all-ones
    assign mac_sum = {1'b0, acc} + {1'b0, prod_nx};
    assign mac_val = mac_sum[2*W] ? {(2*W){1'b1}} : mac_sum[2*W-1:0];
`else
    // accumulator wraps modulo 2^(2W)
    assign mac_val = acc + prod_nx;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state and status outputs; start is only looked at in IDLE, so requests while busy are dropped
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (mode == MODE_ADD || mode == MODE_CLR) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // datapath: operand capture, iterative multiply, accumulator and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            acc    <= '0;
            result <= '0;
            is_mac <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        mcand  <= {{W{1'b0}}, a};
                        mplier <= b;
                        prod   <= '0;
                        is_mac <= (mode == MODE_MAC);
                        if (mode == MODE_ADD) begin
                            result <= add_ext;
                        end
                        if (mode == MODE_CLR) begin
                            acc    <= '0;
                            result <= '0;
                        end
                    end
                end
                RUN: begin
                    cnt    <= cnt + CW'(1);
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    prod   <= prod_nx;
                    // the final step's product goes straight to the result so it is valid during DONE
                    if (last_step) begin
                        if (is_mac) begin
                            acc    <= mac_val;
                            result <= mac_val;
                        end else begin
                            result <= prod_nx;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_mac.sv
// tb/tb_iter_mac.sv - scoreboard testbench for iter_mac with directed vectors
module tb_iter_mac;

    localparam int W = 8;

    localparam logic [1:0] M_ADD = 2'b00;
    localparam logic [1:0] M_MUL = 2'b01;
    localparam logic [1:0] M_MAC = 2'b10;
    localparam logic [1:0] M_CLR = 2'b11;

`ifdef ITER_MAC_SAT_EN
    localparam int MAC2_EXP = 65535;
`else
    localparam int MAC2_EXP = 64514;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [W-1:0]     a = '0;
    logic [W-1:0]     b = '0;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   result;

    int n_cmp = 0;
    int n_bad = 0;
    int sb[$];

    iter_mac #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got result %0d expected no done", result);
            end else begin
                int e;
                e = sb.pop_front();
                chk("result", int'(result), e);
            end
        end
    end

    // launch one op, scramble inputs during RUN, check latency and busy
    task automatic run_op(input string name, input logic [1:0] m, input int av, input int bv,
                          input int exp, input int exp_lat);
        int lat;
        int busy_cnt;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b1;
        mode  = m;
        a     = W'(av);
        b     = W'(bv);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'd1;
        b     = 8'd1;
        lat      = 0;
        busy_cnt = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
            if (lat == 3) begin
                start = 1'b1;
                mode  = M_ADD;
            end
            if (lat == 4) start = 1'b0;
            if (done) break;
        end
        start = 1'b0;
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_busy_cycles"}, busy_cnt, exp_lat);
    endtask

    initial begin
        int t[3];
        int k;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_result", int'(result), 0);
        rst = 1'b0;

        run_op("add_8_9",     M_ADD, 8,   9,   17,    1);
        run_op("add_ff_ff",   M_ADD, 255, 255, 510,   1);
        run_op("mul_3_7",     M_MUL, 3,   7,   21,    9);
        run_op("clr",         M_CLR, 0,   0,   0,     1);
        run_op("mac1_ff",     M_MAC, 255, 255, 65025, 9);
        run_op("mac2_ff",     M_MAC, 255, 255, MAC2_EXP, 9);
        run_op("mul_ff_ff",   M_MUL, 255, 255, 65025, 9);
        run_op("mul_zero",    M_MUL, 0,   200, 0,     9);
        run_op("mac_zero",    M_MAC, 200, 0,   MAC2_EXP, 9);

        // reset during RUN: no done, everything cleared
        @(posedge clk);
        #1;
        start = 1'b1; mode = M_MAC; a = 8'd2; b = 8'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_result", int'(result), 0);
        run_op("mac_after_rst", M_MAC, 1, 1, 1, 9);

        // reset wins over start on the same edge
        @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b1; mode = M_ADD; a = 8'd5; b = 8'd6;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        chk("rst_prio_busy", int'(busy), 0);
        chk("rst_prio_result", int'(result), 0);

        // start held high: back-to-back MULs every W+2 cycles
        @(posedge clk);
        #1;
        start = 1'b1; mode = M_MUL; a = 8'd4; b = 8'd5;
        repeat (3) sb.push_back(20);
        k = 0;
        for (int cyc = 1; cyc <= 80 && k < 3; cyc++) begin
            @(negedge clk);
            if (done) begin
                t[k] = cyc;
                k++;
            end
            if (k == 2 && cyc == t[1] + 3) start = 1'b0;
        end
        start = 1'b0;
        chk("held_done_count", k, 3);
        if (k == 3) begin
            chk("held_interval_1", t[1] - t[0], 10);
            chk("held_interval_2", t[2] - t[1], 10);
        end

        repeat (15) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
